// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: round-robin two-port sequencer in front of a single-port data memory
module data_mem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_BYTES = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ack,
    output logic              p0_err,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic              p1_err,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              grant_id
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    state_t state, state_nx;
    logic last_grant, win, any_req, we_q, oor_q;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] rd_val;
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = any_req ? ACCESS : IDLE;
            ACCESS:  state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end
    always_comb begin
        mem_read  = !reset && state == ACCESS && !we_q && !oor_q;
        mem_write = !reset && state == ACCESS && we_q && !oor_q;
        busy      = state != IDLE;
    end
    assign any_req  = p0_req | p1_req;
    assign win      = (p0_req & p1_req) ? ~last_grant : p1_req;
    assign sel_addr = win ? p1_addr : p0_addr;
    assign rd_val   = (!we_q && !oor_q) ? mem_rdata : '0;
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= 1'b1;
            grant_id   <= 1'b0;
            we_q       <= 1'b0;
            oor_q      <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            p0_ack     <= 1'b0;
            p0_err     <= 1'b0;
            p0_rdata   <= '0;
            p1_ack     <= 1'b0;
            p1_err     <= 1'b0;
            p1_rdata   <= '0;
        end else begin
            p0_ack <= 1'b0;
            p1_ack <= 1'b0;
            if (state == IDLE && any_req) begin
                grant_id   <= win;
                last_grant <= win;
                we_q       <= win ? p1_we : p0_we;
                mem_wdata  <= win ? p1_wdata : p0_wdata;
                mem_addr   <= {sel_addr[ADDR_W-1:2], 2'b00};
                oor_q      <= sel_addr >= ADDR_W'(MEM_BYTES);
            end
            if (state == ACCESS && grant_id) begin
                p1_ack   <= 1'b1;
                p1_err   <= oor_q;
                p1_rdata <= rd_val;
            end
            if (state == ACCESS && !grant_id) begin
                p0_ack   <= 1'b1;
                p0_err   <= oor_q;
                p0_rdata <= rd_val;
            end
        end
    end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed checks of arbitration, sequencing, range and reset abort
module tb_data_mem_arbiter;
    logic clk = 1'b0, reset = 1'b1, mem_init = 1'b1;
    logic p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
    logic [31:0] p0_addr = '0, p0_wdata = '0, p1_addr = '0, p1_wdata = '0;
    logic p0_ack, p0_err, p1_ack, p1_err, mem_read, mem_write, busy, grant_id;
    logic [31:0] p0_rdata, p1_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [31:0] mem [64];
    int n_chk = 0, n_err = 0, a0 = 0, a1 = 0, wr_cnt = 0;
    int t_lat, s0, s1, w0;
    logic t_g, t_acc_w, t_acc_r, t_err;
    logic [31:0] t_acc_addr, t_rd;

    data_mem_arbiter dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(p0_ack), .p0_err(p0_err), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_err(p1_err), .p1_rdata(p1_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pat(int i);
        return (32'(i) * 32'h01010101) ^ 32'h5A5A5A5A;
    endfunction

    // 256-byte memory that ignores upper address bits, so a leaked out-of-range write aliases
    assign mem_rdata = mem[mem_addr[7:2]];
    always @(posedge clk) begin
        if (mem_init) for (int i = 0; i < 64; i++) mem[i] <= pat(i);
        else if (mem_write) mem[mem_addr[7:2]] <= mem_wdata;
        if (mem_write) wr_cnt <= wr_cnt + 1;
        if (p0_ack) a0 <= a0 + 1;
        if (p1_ack) a1 <= a1 + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic txn(input logic p, input logic we, input logic [31:0] a, input logic [31:0] d);
        int lat;
        if (p) begin p1_req = 1'b1; p1_we = we; p1_addr = a; p1_wdata = d; end
        else begin p0_req = 1'b1; p0_we = we; p0_addr = a; p0_wdata = d; end
        tick;
        t_g = grant_id; t_acc_w = mem_write; t_acc_r = mem_read; t_acc_addr = mem_addr;
        p0_req = 1'b0;
        p1_req = 1'b0;
        lat = 1;
        while (!(p ? p1_ack : p0_ack) && lat < 6) begin
            tick;
            lat++;
        end
        t_lat = lat;
        t_rd  = p ? p1_rdata : p0_rdata;
        t_err = p ? p1_err : p0_err;
        tick;
    endtask

    initial begin
        repeat (2) tick;
        mem_init = 1'b0;
        reset = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_grant", grant_id, 0);
        check("rst_acks", {p0_ack, p1_ack, p0_err, p1_err}, 0);
        check("rst_rdata", {p0_rdata, p1_rdata}, 0);
        check("rst_strobes", {mem_read, mem_write}, 0);

        w0 = wr_cnt;
        txn(0, 1, 32'h10, 32'hDEADBEEF);
        check("t1_grant", t_g, 0);
        check("t1_wstrobe", {t_acc_w, t_acc_r}, 2'b10);
        check("t1_addr", t_acc_addr, 32'h10);
        check("t1_wlat", t_lat, 2);
        check("t1_wcount", wr_cnt - w0, 1);
        check("t1_idle_strobe", mem_write, 0);
        txn(0, 0, 32'h10, 32'h0);
        check("t1_rstrobe", {t_acc_w, t_acc_r}, 2'b01);
        check("t1_rlat", t_lat, 2);
        check("t1_rdata", t_rd, 32'hDEADBEEF);
        check("t1_err", t_err, 0);

        reset = 1'b1;
        tick;
        reset = 1'b0;
        s0 = a0; s1 = a1;
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h04;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'h08;
        for (int k = 0; k < 8; k++) begin
            tick;
            check($sformatf("t2_grant%0d", k), grant_id, k % 2);
            tick;
            check($sformatf("t2_ack%0d", k), {p0_ack, p1_ack}, (k % 2) ? 2'b01 : 2'b10);
            check($sformatf("t2_rdata%0d", k), (k % 2) ? p1_rdata : p0_rdata, (k % 2) ? pat(2) : pat(1));
            tick;
            check($sformatf("t2_idle%0d", k), busy, 0);
        end
        p0_req = 1'b0;
        p1_req = 1'b0;
        check("t2_acks0", a0 - s0, 4);
        check("t2_acks1", a1 - s1, 4);

        w0 = wr_cnt;
        txn(1, 1, 32'h100, 32'hCAFEF00D);
        check("t3_grant", t_g, 1);
        check("t3_strobes", {t_acc_w, t_acc_r}, 0);
        check("t3_lat", t_lat, 2);
        check("t3_err", t_err, 1);
        check("t3_rdata", t_rd, 0);
        check("t3_wcount", wr_cnt - w0, 0);
        txn(0, 0, 32'h0, 32'h0);
        check("t3_word0", t_rd, pat(0));
        check("t3_word0_err", t_err, 0);

        txn(0, 1, 32'h13, 32'h12345678);
        check("t4_wlat", t_lat, 2);
        txn(0, 0, 32'h10, 32'h0);
        check("t4_rdata", t_rd, 32'h12345678);

        w0 = wr_cnt; s0 = a0;
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 32'h20; p0_wdata = 32'hA5A5A5A5;
        tick;
        check("t5_access", busy, 1);
        p0_req = 1'b0;
        reset = 1'b1;
        #1;
        check("t5_wgate", mem_write, 0);
        tick;
        reset = 1'b0;
        check("t5_idle", busy, 0);
        repeat (3) tick;
        check("t5_noack", a0 - s0, 0);
        check("t5_wcount", wr_cnt - w0, 0);
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h20;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'h00;
        tick;
        check("t5_grant", grant_id, 0);
        p0_req = 1'b0;
        p1_req = 1'b0;
        tick;
        check("t5_ack", p0_ack, 1);
        check("t5_word8", p0_rdata, pat(8));
        tick;

        s0 = a0;
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h08;
        tick;
        p0_addr = 32'h0C;
        p0_req = 1'b0;
        #1;
        check("t6_addr", mem_addr, 32'h08);
        check("t6_read", mem_read, 1);
        tick;
        check("t6_ack", p0_ack, 1);
        check("t6_rdata", p0_rdata, pat(2));
        repeat (3) tick;
        check("t6_acks", a0 - s0, 1);
        check("t6_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
